// File: rtl/param_updown_counter_if.sv
// param_updown_counter_if: control and status bundle of the modulo-N up/down counter
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, tc, wrap
    );
endinterface

// File: rtl/param_updown_counter.sv
// param_updown_counter: prescaled modulo-N up/down counter built from per-bit toggle stages
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input logic                  sysclk,
    input logic                  rst_n,
    param_updown_counter_if.slave bus
);
    localparam int               PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [PS_W-1:0]  r_ps;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_sat;
    logic             w_step;
    logic             w_ps_last;
    logic             w_at_end;

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    for (genvar i = 0; i < WIDTH; i++) begin : g_tog
        localparam logic [WIDTH-1:0] LOW = WIDTH'((64'd1 << i) - 64'd1);
        assign w_tog[i] = bus.up_dn ? ((r_q & LOW) == LOW) : ((r_q & LOW) == '0);
    end

    assign w_ps_last  = (r_ps == PS_LAST);
    assign w_step     = bus.en & w_ps_last;
    assign w_at_end   = bus.up_dn ? (r_q == Q_MAX) : (r_q == '0);
    assign w_load_sat = ({1'b0, bus.load_val} >= MOD_EXT) ? Q_MAX : bus.load_val;
    // A wrap step overrides the toggle result with the range end for the new direction.
    assign w_next     = w_at_end ? (bus.up_dn ? '0 : Q_MAX) : (r_q ^ w_tog);

    assign bus.q    = r_q;
    assign bus.wrap = r_wrap;
    assign bus.tc   = w_at_end;

    // Count state: reset beats load, load beats a step, otherwise step or hold.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ps   <= '0;
        end else if (bus.load) begin
            r_q    <= w_load_sat;
            r_wrap <= 1'b0;
            r_ps   <= '0;
        end else begin
            if (bus.en) r_ps <= w_ps_last ? '0 : r_ps + 1'b1;
            r_q    <= w_step ? w_next : r_q;
            r_wrap <= w_step & w_at_end;
        end
    end
endmodule
